xor5_rr_arbiter: RTL and testbench

- Shares one 5-bit XOR datapath (instance of the team's _5bit_xor) between two requesters.
- Round-robin arbitration, valid/ready handshake on both request ports and on the single result port.
- Registered operands and result; one operation in flight at a time.
- Sits between the ALU-level control and the bitwise XOR slice, so two clients can share one XOR unit.

---
 rtl/xor5_rr_arbiter.sv | 111 +++++++++++
 tb/tb_xor5_rr_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/xor5_rr_arbiter.sv
// Two-requester round-robin front end sharing one 5-bit XOR slice.
// Operands and result are registered, and only one operation is in flight at a time.

module _5bit_xor (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] y
);
    assign y = a ^ b;
endmodule

module xor5_rr_arbiter #(
    parameter int unsigned FIRST_GRANT = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [4:0]       req0_a,
    input  logic [4:0]       req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_a,
    input  logic [4:0]       req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [4:0]       res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic FG = 1'(FIRST_GRANT);

    state_t     state, state_nxt;
    logic       gnt_any, gnt;
    logic [4:0] opa, opb, xor_y;
    logic       idr, last_grant;

    _5bit_xor u_xor (
        .a (opa),
        .b (opb),
        .y (xor_y)
    );

    // When both requesters are valid, the one not served last wins.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) gnt = ~last_grant;
        else                          gnt = req1_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && gnt_any) begin
            req0_ready = ~gnt;
            req1_ready = gnt;
        end
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa        <= '0;
            opb        <= '0;
            idr        <= 1'b0;
            last_grant <= ~FG;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    opa        <= gnt ? req1_a : req0_a;
                    opb        <= gnt ? req1_b : req0_b;
                    idr        <= gnt;
                    last_grant <= gnt;
                end
                EXEC: begin
                    res_data  <= xor_y;
                    res_id    <= idr;
                    res_valid <= 1'b1;
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    op_count  <= op_count + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xor5_rr_arbiter.sv
// Directed bench for xor5_rr_arbiter with a transaction-level reference model
// checked every cycle, plus literal checks from hand-worked vectors.

module tb_xor5_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, res_ready;
    logic [4:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready, res_valid, res_id, busy;
    logic [4:0] res_data;
    logic [7:0] op_count;
    logic       w_req0_ready, w_req1_ready, w_res_valid, w_res_id, w_busy;
    logic [4:0] w_res_data;
    logic [1:0] op_count_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor5_rr_arbiter #(.FIRST_GRANT(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
        .busy(busy), .op_count(op_count)
    );

    xor5_rr_arbiter #(.FIRST_GRANT(0), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(w_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(w_req1_ready),
        .res_valid(w_res_valid), .res_data(w_res_data), .res_id(w_res_id), .res_ready(res_ready),
        .busy(w_busy), .op_count(op_count_w)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an operation is either absent, in its first cycle
    // after acceptance (result not yet visible), or presenting its result.
    bit       m_init = 0;
    bit       m_have;
    bit       m_shown;
    bit       m_last;
    bit       m_id, m_rid;
    bit [4:0] m_a, m_b, m_res;
    bit [7:0] m_count;

    always @(negedge clk) begin
        bit e0, e1, g, any;
        any = req0_valid || req1_valid;
        g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e0  = m_init && !m_have && any && !g;
        e1  = m_init && !m_have && any && g;
        if (m_init) begin
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("busy", busy, m_have);
            chk("res_valid", res_valid, m_have && m_shown);
            chk("op_count", op_count, m_count);
            chk("op_count_w", op_count_w, m_count % 4);
            chk("w_res_valid", w_res_valid, m_have && m_shown);
            if (m_have && m_shown) begin
                chk("res_data", res_data, m_res);
                chk("res_id", res_id, m_rid);
            end
        end
        if (rst) begin
            m_init = 1; m_have = 0; m_shown = 0; m_last = 1'b1;
            m_count = 0; m_res = 0; m_rid = 0;
        end else if (m_init) begin
            if (!m_have) begin
                if (any) begin
                    m_have = 1; m_shown = 0; m_id = g; m_last = g;
                    m_a = g ? req1_a : req0_a;
                    m_b = g ? req1_b : req0_b;
                end
            end else if (!m_shown) begin
                m_shown = 1; m_res = m_a ^ m_b; m_rid = m_id;
            end else if (res_ready) begin
                m_have = 0; m_shown = 0; m_count = m_count + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; req0_valid = 0; req1_valid = 0; res_ready = 1;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        tick(); tick(); rst = 0;
        look();
        chk("rst res_valid", res_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst op_count", op_count, 0);

        // idle with no requests
        repeat (3) tick();
        look();
        chk("idle ready0", req0_ready, 0);
        chk("idle ready1", req1_ready, 0);
        chk("idle busy", busy, 0);

        // single requester
        tick(); req0_valid = 1; req0_a = 5'b00011; req0_b = 5'b00010;
        look(); chk("t1 ready0", req0_ready, 1);
        tick(); req0_valid = 0;
        look(); chk("t1 exec busy", busy, 1); chk("t1 exec res_valid", res_valid, 0);
        tick(); look();
        chk("t1 res_valid", res_valid, 1);
        chk("t1 res_data", res_data, 5'b00001);
        chk("t1 res_id", res_id, 0);
        tick(); look();
        chk("t1 op_count", op_count, 1);
        chk("t1 op_count_w", op_count_w, 1);
        chk("t1 idle", busy, 0);

        // simultaneous requests after a fresh reset
        tick(); rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_a = 5'b01100; req0_b = 5'b01110;
        req1_valid = 1; req1_a = 5'b01010; req1_b = 5'b10001;
        look(); chk("t2 first grant0", req0_ready, 1); chk("t2 first grant1", req1_ready, 0);
        tick(); tick(); look();
        chk("t2 r1 data", res_data, 5'b00010); chk("t2 r1 id", res_id, 0);
        tick(); look(); chk("t2 second grant1", req1_ready, 1);
        tick(); tick(); look();
        chk("t2 r2 data", res_data, 5'b11011); chk("t2 r2 id", res_id, 1);
        tick(); req0_a = 5'b11111; req0_b = 5'b00000;
        look(); chk("t2 alt grant0", req0_ready, 1);
        tick(); tick(); look();
        chk("t2 r3 data", res_data, 5'b11111); chk("t2 r3 id", res_id, 0);
        tick();
        chk("t2 op_count_w", op_count_w, 3);

        // backpressure on the result port
        res_ready = 0;
        req1_a = 5'b00111; req1_b = 5'b00000;
        req0_a = 5'b00001; req0_b = 5'b00001;
        look(); chk("t3 grant1", req1_ready, 1);
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            look();
            chk("t3 hold valid", res_valid, 1);
            chk("t3 hold data", res_data, 5'b00111);
            chk("t3 hold ready0", req0_ready, 0);
            chk("t3 hold ready1", req1_ready, 0);
            tick();
        end
        res_ready = 1; req1_valid = 0;
        tick(); look();
        chk("t3 op_count", op_count, 4);
        chk("t3 op_count_w wrap", op_count_w, 0);
        // identical operands
        chk("t4 grant0", req0_ready, 1);
        tick(); tick(); look();
        chk("t4 res_data", res_data, 5'b00000); chk("t4 res_id", res_id, 0);
        tick(); req0_valid = 0;
        look(); chk("t4 op_count", op_count, 5);

        // reset in EXEC
        tick(); req0_valid = 1; req0_a = 5'b00001; req0_b = 5'b00100;
        look(); chk("t5 ready0", req0_ready, 1);
        tick(); rst = 1; req0_valid = 0;
        tick(); rst = 0;
        look();
        chk("t5 res_valid", res_valid, 0);
        chk("t5 res_data", res_data, 0);
        chk("t5 op_count", op_count, 0);
        chk("t5 busy", busy, 0);
        tick(); req0_valid = 1; req1_valid = 1;
        look(); chk("t5 first grant0", req0_ready, 1); chk("t5 first grant1", req1_ready, 0);
        tick(); req0_valid = 0; req1_valid = 0;
        tick(); tick(); tick(); look();
        chk("t5 op_count", op_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
